// File: rtl/id_ex_imm_stage.sv
// rtl/id_ex_imm_stage.sv - ID->EX immediate-path stage with 2-entry skid buffer
module id_ex_imm_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc_plus4,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_sel,
    input  logic [31:0]      in_sext16,
    input  logic [31:0]      in_zext16,
    input  logic [31:0]      in_sext18,
    input  logic [31:0]      in_sext8,
    input  logic [31:0]      in_zext8,
    input  logic [31:0]      in_zext5,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_br_target,
    output logic [31:0]      out_pc_plus4,
    output logic [31:0]      out_instr,
    output logic             out_bad_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    // Occupancy encoded as {out_valid, skid_valid}; 01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t state;

    logic [31:0] sel_imm;
    logic        sel_bad;
    logic [31:0] sel_br;
    logic        acc;

    logic [31:0] skid_imm;
    logic [31:0] skid_br;
    logic [31:0] skid_pc_plus4;
    logic [31:0] skid_instr;
    logic        skid_bad;

    assign out_valid = state[1];
    assign in_ready  = ~state[0];
    assign acc       = in_valid & in_ready;

    // Immediate select and branch target are resolved before capture so the
    // skid slot only ever holds finished values.
    always_comb begin
        sel_imm = 32'd0;
        sel_bad = 1'b0;
        case (in_imm_sel)
            3'd0:    sel_imm = in_sext16;
            3'd1:    sel_imm = in_zext16;
            3'd2:    sel_imm = in_sext18;
            3'd3:    sel_imm = in_sext8;
            3'd4:    sel_imm = in_zext8;
            3'd5:    sel_imm = in_zext5;
            default: sel_bad = 1'b1;
        endcase
        sel_br = in_pc_plus4 + in_sext18;
    end

    // Occupancy and payload movement; flush empties both slots and drops any
    // same-cycle accept. Out data is only rewritten when out is free or consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            out_imm       <= 32'd0;
            out_br_target <= 32'd0;
            out_pc_plus4  <= 32'd0;
            out_instr     <= 32'd0;
            out_bad_sel   <= 1'b0;
            skid_imm      <= 32'd0;
            skid_br       <= 32'd0;
            skid_pc_plus4 <= 32'd0;
            skid_instr    <= 32'd0;
            skid_bad      <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        state         <= ONE;
                        out_imm       <= sel_imm;
                        out_br_target <= sel_br;
                        out_pc_plus4  <= in_pc_plus4;
                        out_instr     <= in_instr;
                        out_bad_sel   <= sel_bad;
                    end
                end
                ONE: begin
                    if (acc && out_ready) begin
                        out_imm       <= sel_imm;
                        out_br_target <= sel_br;
                        out_pc_plus4  <= in_pc_plus4;
                        out_instr     <= in_instr;
                        out_bad_sel   <= sel_bad;
                    end else if (acc) begin
                        state         <= TWO;
                        skid_imm      <= sel_imm;
                        skid_br       <= sel_br;
                        skid_pc_plus4 <= in_pc_plus4;
                        skid_instr    <= in_instr;
                        skid_bad      <= sel_bad;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        state         <= ONE;
                        out_imm       <= skid_imm;
                        out_br_target <= skid_br;
                        out_pc_plus4  <= skid_pc_plus4;
                        out_instr     <= skid_instr;
                        out_bad_sel   <= skid_bad;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of cycles EX held a valid entry back; flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
